// File: rtl/psr_cond_unit_pkg.sv
// Shared definitions for the PSR / condition unit.
//   - Flag bit positions inside the 5-bit PSR (C F L Z N = bits 0..4).
//   - The sixteen 4-bit condition codes used by Bcond/Jcond/Scond.
//   - Output buffer state encoding, exposed on the top-level debug port.
package psr_cond_unit_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_F = 1;
  localparam int FLAG_L = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/psr_cond_unit_if.sv
// Condition request / decision interface.
//   master : control FSM + PC logic side (drives requests, consumes decisions)
//   slave  : psr_cond_unit
// Handshake: both channels are strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high; valid may not depend on
// ready, and payload must be held stable while valid is high and ready low.
//   req_*  : request channel (cond code + branch target), master -> slave
//   out_*  : decision channel (taken, target, Scond value), slave -> master
interface psr_cond_unit_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cond;
  logic [WIDTH-1:0] req_target;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [WIDTH-1:0] out_target;
  logic [WIDTH-1:0] out_scond;

  modport master (
    output req_valid, req_cond, req_target, out_ready,
    input  req_ready, out_valid, out_taken, out_target, out_scond
  );

  modport slave (
    input  req_valid, req_cond, req_target, out_ready,
    output req_ready, out_valid, out_taken, out_target, out_scond
  );
endinterface

// File: rtl/psr_cond_unit_cond_eval.sv
// Combinational condition evaluator.
//   flags : 5-bit PSR value (C F L Z N = bits 0..4)
//   cond  : 4-bit condition code
//   taken : 1 when the condition holds for the given flags
module psr_cond_unit_cond_eval
  import psr_cond_unit_pkg::*;
(
  input  logic [4:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic c, f, l, z, n;

  assign c = flags[FLAG_C];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// Processor status register and branch-condition decision unit.
//   clk, reset_n           : clock, asynchronous active-low reset
//   flag_in, flag_we       : ALU flag values and per-bit write mask
//   psr_load, psr_load_data: full PSR load (LPR), overrides flag_we
//   psr                    : current registered PSR
//   bus (slave)            : condition request in, registered decision out
//   taken_count            : count of consumed taken decisions (wraps)
//   buf_state              : output buffer state, for observation
module psr_cond_unit
  import psr_cond_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       flag_in,
  input  logic [4:0]       flag_we,
  input  logic             psr_load,
  input  logic [4:0]       psr_load_data,
  output logic [4:0]       psr,
  psr_cond_unit_if.slave   bus,
  output logic [CNT_W-1:0] taken_count,
  output buf_state_t       buf_state
);

  logic [4:0]       eff;
  logic             eval_taken;
  logic             accept;
  logic             taken_q;
  logic [WIDTH-1:0] target_q;

  // Flags as they will stand after this edge, so a branch issued in the
  // same cycle as the flag-setting instruction sees the new flags.
  assign eff = psr_load ? psr_load_data : ((psr & ~flag_we) | (flag_in & flag_we));

  psr_cond_unit_cond_eval u_cond_eval (
    .flags (eff),
    .cond  (bus.req_cond),
    .taken (eval_taken)
  );

  // A full buffer can take a new request in the same edge it is drained.
  assign bus.req_ready  = (buf_state == BUF_EMPTY) || bus.out_ready;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.out_valid  = (buf_state == BUF_FULL);
  assign bus.out_taken  = taken_q;
  assign bus.out_target = target_q;
  assign bus.out_scond  = {{(WIDTH-1){1'b0}}, taken_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr         <= '0;
      buf_state   <= BUF_EMPTY;
      taken_q     <= 1'b0;
      target_q    <= '0;
      taken_count <= '0;
    end else begin
      psr <= eff;

      if (bus.out_valid && bus.out_ready && taken_q) begin
        taken_count <= taken_count + CNT_W'(1);
      end

      case (buf_state)
        BUF_EMPTY: begin
          if (accept) begin
            taken_q   <= eval_taken;
            target_q  <= bus.req_target;
            buf_state <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (accept) begin
            taken_q   <= eval_taken;
            target_q  <= bus.req_target;
          end else if (bus.out_ready) begin
            buf_state <= BUF_EMPTY;
          end
        end
        default: buf_state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_psr_cond_unit.sv
module tb_psr_cond_unit;
  import psr_cond_unit_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic [4:0]       flag_in;
  logic [4:0]       flag_we;
  logic             psr_load;
  logic [4:0]       psr_load_data;
  logic [4:0]       psr;
  logic [CNT_W-1:0] taken_count;
  buf_state_t       buf_state;

  int checks;
  int errors;

  psr_cond_unit_if #(.WIDTH(WIDTH)) bus ();

  psr_cond_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flag_in       (flag_in),
    .flag_we       (flag_we),
    .psr_load      (psr_load),
    .psr_load_data (psr_load_data),
    .psr           (psr),
    .bus           (bus),
    .taken_count   (taken_count),
    .buf_state     (buf_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_in        = '0;
    flag_we        = '0;
    psr_load       = 1'b0;
    psr_load_data  = '0;
    bus.req_valid  = 1'b0;
    bus.req_cond   = '0;
    bus.req_target = '0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    flag_we = 5'h1F;
    flag_in = 5'h1F;
    bus.req_valid = 1'b1;
    bus.req_cond  = COND_UC;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (psr !== 5'h00) begin errors++; $display("FAIL reset_psr got %h exp %h", psr, 5'h00); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (taken_count !== 16'h0000) begin errors++; $display("FAIL reset_taken_count got %h exp 0000", taken_count); end
    checks++; if (bus.out_taken !== 1'b0) begin errors++; $display("FAIL reset_out_taken got %b exp 0", bus.out_taken); end
    checks++; if (bus.out_target !== 16'h0000) begin errors++; $display("FAIL reset_out_target got %h exp 0000", bus.out_target); end
    checks++; if (bus.out_scond !== 16'h0000) begin errors++; $display("FAIL reset_out_scond got %h exp 0000", bus.out_scond); end
    idle_inputs();
    reset_n = 1'b1;
    #2;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    tick();
  endtask

  task automatic test_masked_write();
    psr_load = 1'b1; psr_load_data = 5'b00001;
    tick();
    psr_load = 1'b0;
    checks++; if (psr !== 5'b00001) begin errors++; $display("FAIL load_psr got %b exp 00001", psr); end
    flag_in = 5'b01000; flag_we = 5'b01000;
    tick();
    checks++; if (psr !== 5'b01001) begin errors++; $display("FAIL masked_write got %b exp 01001", psr); end
    psr_load = 1'b1; psr_load_data = 5'b10000;
    flag_in = 5'h1F; flag_we = 5'h1F;
    tick();
    idle_inputs();
    checks++; if (psr !== 5'b10000) begin errors++; $display("FAIL load_priority got %b exp 10000", psr); end
  endtask

  task automatic test_forwarding();
    // psr is 10000 here; Z is written in the same cycle as the EQ request
    flag_we = 5'b01000; flag_in = 5'b01000;
    bus.req_valid = 1'b1; bus.req_cond = COND_EQ; bus.req_target = 16'h0040;
    tick();
    idle_inputs();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_taken !== 1'b1) begin errors++; $display("FAIL fwd_taken got %b exp 1", bus.out_taken); end
    checks++; if (bus.out_target !== 16'h0040) begin errors++; $display("FAIL fwd_target got %h exp 0040", bus.out_target); end
    checks++; if (bus.out_scond !== 16'h0001) begin errors++; $display("FAIL fwd_scond got %h exp 0001", bus.out_scond); end
    checks++; if (psr !== 5'b11000) begin errors++; $display("FAIL fwd_psr got %b exp 11000", psr); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_all_codes();
    logic [4:0]  pats  [5];
    logic [15:0] masks [5];
    logic [15:0] m;
    pats[0] = 5'b00000; masks[0] = 16'h56AA;
    pats[1] = 5'b01000; masks[1] = 16'h6AA9;
    pats[2] = 5'b00100; masks[2] = 16'h5A9A;
    pats[3] = 5'b10000; masks[3] = 16'h666A;
    pats[4] = 5'b00011; masks[4] = 16'h55A6;
    for (int p = 0; p < 5; p++) begin
      idle_inputs();
      psr_load = 1'b1; psr_load_data = pats[p];
      tick();
      psr_load = 1'b0;
      checks++; if (psr !== pats[p]) begin errors++; $display("FAIL codes_psr_load got %b exp %b", psr, pats[p]); end
      m = masks[p];
      bus.out_ready = 1'b1;
      bus.req_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        bus.req_cond   = 4'(c);
        bus.req_target = 16'(16'h0100 + c);
        tick();
        checks++;
        if (bus.out_taken !== m[c] || bus.out_scond !== {15'b0, m[c]} || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL cond_code psr=%b cond=%0d got taken=%b scond=%h valid=%b exp taken=%b",
                   pats[p], c, bus.out_taken, bus.out_scond, bus.out_valid, m[c]);
        end
      end
      bus.req_valid = 1'b0;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    psr_load = 1'b1; psr_load_data = 5'b01000;
    tick();
    psr_load = 1'b0;
    bus.req_valid = 1'b1; bus.req_cond = COND_EQ; bus.req_target = 16'h1234;
    tick();
    bus.req_cond = COND_NE; bus.req_target = 16'h5678;
    flag_we = 5'h1F; flag_in = 5'h00;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle %0d got %b exp 0", i, bus.req_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b1 || bus.out_target !== 16'h1234) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b taken=%b target=%h exp 1 1 1234",
                 i, bus.out_valid, bus.out_taken, bus.out_target);
      end
    end
    checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL bp_psr got %b exp 00000", psr); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.req_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b1 || bus.out_target !== 16'h5678) begin
      errors++;
      $display("FAIL b2b_first got valid=%b taken=%b target=%h exp 1 1 5678",
               bus.out_valid, bus.out_taken, bus.out_target);
    end
    bus.req_cond = COND_EQ; bus.req_target = 16'h9ABC;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b0 || bus.out_target !== 16'h9ABC) begin
      errors++;
      $display("FAIL b2b_second got valid=%b taken=%b target=%h exp 1 0 9abc",
               bus.out_valid, bus.out_taken, bus.out_target);
    end
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid); end
    idle_inputs();
  endtask

  task automatic test_counter();
    logic [3:0] seq [8];
    seq[0] = COND_UC; seq[1] = COND_NV; seq[2] = COND_UC; seq[3] = COND_UC;
    seq[4] = COND_NV; seq[5] = COND_UC; seq[6] = COND_NV; seq[7] = COND_UC;
    idle_inputs();
    pulse_reset();
    checks++; if (taken_count !== 16'h0000) begin errors++; $display("FAIL cnt_start got %h exp 0000", taken_count); end
    bus.out_ready = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req_cond = seq[i];
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    checks++; if (taken_count !== 16'd5) begin errors++; $display("FAIL cnt_mixed got %0d exp 5", taken_count); end

    pulse_reset();
    bus.out_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_cond  = COND_UC;
    for (int i = 0; i < 65535; i++) tick();
    bus.req_valid = 1'b0;
    tick();
    checks++; if (taken_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_preload got %h exp ffff", taken_count); end
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++; if (taken_count !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h exp 0000", taken_count); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    psr_load = 1'b1; psr_load_data = 5'b01000;
    bus.req_valid = 1'b1; bus.req_cond = COND_EQ; bus.req_target = 16'hBEEF;
    tick();
    idle_inputs();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", bus.out_valid); end
    flag_we = 5'h1F; flag_in = 5'h1F;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || psr !== 5'h00 || bus.out_target !== 16'h0000 || bus.out_taken !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b psr=%b target=%h taken=%b exp 0 00000 0000 0",
               bus.out_valid, psr, bus.out_target, bus.out_taken);
    end
    tick();
    checks++; if (psr !== 5'h00) begin errors++; $display("FAIL mid_reset_hold got %b exp 00000", psr); end
    idle_inputs();
    reset_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", bus.req_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %b exp 0", bus.out_valid); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_masked_write();
    test_forwarding();
    test_all_codes();
    test_backpressure();
    test_counter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psr_cond_unit.md
Name: psr_cond_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural processor status register (PSR) and merges ALU flag updates under a per-bit write mask.
- Evaluates the 4-bit CR16-style condition codes used by Bcond/Jcond/Scond, and returns a registered decision to the fetch/PC logic over a valid/ready handshake.
- Sits between the ALU flag outputs, the control FSM (which issues condition requests) and the PC update logic.

Parameters:
- WIDTH, 16, datapath width of the branch target and the Scond result.
- CNT_W, 16, width of the taken-branch statistics counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- flag_in  in  5  ALU flags; bit order C F L Z N = bits 0..4.
- flag_we  in  5  per-bit write mask; PSR[i] takes flag_in[i] when flag_we[i]=1.
- psr_load  in  1  full PSR load (LPR instruction).
- psr_load_data  in  5  value loaded when psr_load=1.
- psr  out  5  current registered PSR.
- req_valid  in  1  control FSM presents a condition request.
- req_ready  out  1  unit can accept a request this cycle.
- req_cond  in  4  condition code.
- req_target  in  WIDTH  branch target carried with the request.
- out_valid  out  1  decision available.
- out_ready  in  1  PC logic consumes the decision.
- out_taken  out  1  condition true.
- out_target  out  WIDTH  target echoed from the request.
- out_scond  out  WIDTH  zero-extended out_taken (1 or 0), for Scond.
- taken_count  out  CNT_W  number of consumed decisions with out_taken=1.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - psr=0, out_valid=0, out_taken=0, out_target=0, out_scond=0, taken_count=0.
  - req_ready=1 once reset releases.
- PSR update on each rising edge:
  - If psr_load=1: psr <= psr_load_data, and flag_we is ignored that cycle.
  - Else, for each bit i: psr[i] <= flag_we[i] ? flag_in[i] : psr[i].
- Effective flags for evaluation (eff): the value psr will hold after the current edge, i.e. same-cycle writes are forwarded.
- Condition table, true when:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: always true
  - 1111: never true
- Output buffer: one entry, states EMPTY and FULL.
  - req_ready = EMPTY | (FULL & out_ready).
  - Request accepted on an edge where req_valid & req_ready. out_taken, out_target and out_scond load from the condition evaluated on eff; state becomes FULL.
  - Latency: decision is visible one cycle after acceptance.
  - FULL & out_ready with no new request: state becomes EMPTY, out_valid drops.
  - FULL & out_ready & req_valid: the buffer is replaced in the same edge and stays FULL. This gives back-to-back throughput of 1 per cycle.
  - FULL & !out_ready: outputs hold stable and req_ready=0. Later PSR changes do not alter the held decision.
- taken_count increments on each edge where out_valid & out_ready & out_taken, and wraps modulo 2^CNT_W.
- out_scond = {WIDTH-1 zeros, out_taken}.
- Reset asserted mid-transaction discards the pending decision. No partial state survives.

Decomposition:
- Shared package/header:
  - flag bit indices FLAG_C=0, FLAG_F=1, FLAG_L=2, FLAG_Z=3, FLAG_N=4.
  - the 16 condition code constants (COND_EQ .. COND_NV).
  - ALU and the decoder include the same file.
- Sub-module cond_eval: purely combinational, (flags[4:0], cond[3:0]) -> taken. It is reused by the decoder for Scond.

Test Plan:
- Reset: hold reset_n=0 mid-run with flag_we=5'h1F and flag_in=5'h1F -> psr=0, out_valid=0, taken_count=0; after release req_ready=1.
- Masked write: psr=5'b00001, flag_in=5'b01000, flag_we=5'b01000 -> psr=5'b01001. Then psr_load=1 with data 5'b10000 and flag_we=5'h1F in the same cycle -> psr=5'b10000.
- Forwarding: in the same cycle flag_we=5'b01000, flag_in Z=1, req cond=EQ, target=16'h0040 -> next cycle out_valid=1, out_taken=1, out_target=16'h0040, out_scond=16'h0001.
- All 16 codes: sweep each code against psr in {5'b00000, 5'b01000, 5'b00100, 5'b10000, 5'b00011} -> out_taken matches the table; 1110 is always 1 and 1111 is always 0.
- Backpressure: out_ready=0 for 3 cycles while psr changes -> outputs stable, req_ready=0. Raise out_ready with a new request pending -> back-to-back acceptance with no bubble.
- Counter: 5 taken and 3 not-taken decisions consumed -> taken_count=5. Preload via 16'hFFFF taken consumptions, then one more taken -> taken_count wraps to 0.
